// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef logic [31:0] word_t;

    // Word-index width for a power-of-two depth.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, contents not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  word_t         wdata,
    input  logic [AW-1:0] ridx,
    output word_t         rdata
);

    word_t r_mem [DEPTH];

    // Word write on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= wdata;
        end
    end

    assign rdata = r_mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store target with fixed LATENCY and a busy stall output.
// Optional build macro DMEM_ERR_EN flags misaligned / out-of-range accesses via rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

    dmem_state_e   r_state;
    dmem_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          r_we;
    logic [AW-1:0] r_idx;
    word_t         r_wdata;
    logic          r_err;

    logic          r_rsp_valid;
    word_t         r_rsp_rdata;
    logic          r_rsp_err;

    logic [AW-1:0] w_req_idx;
    logic          w_req_err;
    logic          w_accept;
    logic          w_enter_resp;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_idx;
    logic          w_sel_err;
    logic          w_mem_we;
    word_t         w_mem_rdata;

    assign w_req_idx = req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
`else
    logic w_unused;
    assign w_req_err = 1'b0;
    assign w_unused  = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_state_nxt == RESP);

    // With LATENCY==1 RESP is entered straight from IDLE, before the request is latched.
    assign w_sel_we  = (r_state == IDLE) ? req_we    : r_we;
    assign w_sel_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_sel_err = (r_state == IDLE) ? w_req_err : r_err;

    assign w_mem_we  = (r_state == RESP) && r_we && !r_err;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .widx  (r_idx),
        .wdata (r_wdata),
        .ridx  (w_sel_idx),
        .rdata (w_mem_rdata)
    );

    // State, counter, latched request and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_enter_resp;
            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= w_req_idx;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
            end
            if (w_enter_resp) begin
                r_rsp_err <= w_sel_err;
                if (!w_sel_we) begin
                    r_rsp_rdata <= w_sel_err ? 32'd0 : w_mem_rdata;
                end
            end else begin
                r_rsp_err <= 1'b0;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = ((r_state == IDLE) && req_valid) || (r_state == WAIT);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
